betting_round_ctrl: RTL and testbench

Sequences one betting round (pre-flop, flop, turn or river) of a hand: rotates the turn among seated players still in the hand and decodes each check/call, bet/raise or fold. It drives the per-player bet port (`player_en`/`make_bet`/`bet_amount`) and reports the chips added to the pot. It signals when the round has closed or when only one player remains. The hand FSM instantiates it and pulses `start` once per betting stage.

---
 rtl/betting_round_ctrl_pkg.sv | 32 +++
 rtl/betting_round_ctrl_seat_rotator.sv | 25 ++
 rtl/betting_round_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_betting_round_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/betting_round_ctrl_pkg.sv
// Shared types for the betting-round controller: action decode, FSM states, default raise step.
// Pure declarations; no timing or flow control.
package betting_round_ctrl_pkg;

    localparam int BET_UNIT_DEFAULT = 10;
    localparam int NUM_SEATS        = 8;

    typedef enum logic [1:0] {
        act_none,
        act_check_call,
        act_bet_raise,
        act_fold
    } action_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEEK,
        S_WAIT_ACT,
        S_APPLY,
        S_CHECK
    } state_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/betting_round_ctrl_seat_rotator.sv
// Rotating priority encoder: first set bit of mask_i at or after start_i, modulo 8.
// Combinational, zero latency; no flow control.
module seat_rotator (
    input  logic [7:0] mask_i,
    input  logic [2:0] start_i,
    output logic [2:0] idx_o,
    output logic       found_o
);

    logic [2:0] cand;

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int k = 0; k < 8; k++) begin
            cand = start_i + 3'(k);
            if (!found_o && mask_i[cand]) begin
                idx_o   = cand;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/betting_round_ctrl.sv
// Runs one betting round: rotates the turn, applies check/call, bet/raise or fold, reports pot adds.
// start -> first turn 2 cycles; advance -> make_bet next cycle; actions only accepted in WAIT_ACT.
module betting_round_ctrl
    import betting_round_ctrl_pkg::*;
#(
    parameter int BET_UNIT = BET_UNIT_DEFAULT,
    parameter int CHIP_W   = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            active_in,
    input  logic [2:0]            first_seat,
    input  logic                  advance,
    input  logic                  check_or_call,
    input  logic                  bet_or_raise,
    input  logic                  fold,
    input  logic [8*CHIP_W-1:0]   stacks,
    output logic                  busy,
    output logic [2:0]            player_turn,
    output logic [7:0]            player_en,
    output logic                  make_bet,
    output logic [CHIP_W-1:0]     bet_amount,
    output logic [CHIP_W-1:0]     pot_add,
    output logic [7:0]            active_out,
    output logic                  round_done,
    output logic                  hand_won,
    output logic [2:0]            winner
);

    state_t              state_q, state_d;
    logic [7:0]          active_q, active_d;
    logic [7:0]          acted_q, acted_d;
    logic [2:0]          ptr_q, ptr_d;
    logic [CHIP_W-1:0]   cur_bet_q, cur_bet_d;
    logic [CHIP_W-1:0]   contrib_q [8];
    logic [CHIP_W-1:0]   contrib_d [8];
    logic                busy_q, busy_d;
    logic                make_bet_q, make_bet_d;
    logic [7:0]          player_en_q, player_en_d;
    logic [CHIP_W-1:0]   bet_amt_q, bet_amt_d;
    logic                round_done_q, round_done_d;
    logic                hand_won_q, hand_won_d;
    logic [2:0]          winner_q, winner_d;

    logic [CHIP_W-1:0]   stk [8];
    logic [7:0]          eligible;
    logic                closed;
    logic [2:0]          seek_idx, win_idx;
    logic                seek_found, win_found;
    action_t             act;
    logic [CHIP_W-1:0]   owe, need, amt, new_contrib, target;
    logic [CHIP_W:0]     target_wide;

    always_comb begin
        eligible = '0;
        closed   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            stk[i]      = stacks[i*CHIP_W +: CHIP_W];
            eligible[i] = active_q[i] && (stk[i] != '0);
            // All-in seats count as matched even below cur_bet
            if (eligible[i] && !(acted_q[i] && (contrib_q[i] == cur_bet_q)))
                closed = 1'b0;
        end
    end

    seat_rotator u_seek (
        .mask_i  (eligible),
        .start_i (ptr_q),
        .idx_o   (seek_idx),
        .found_o (seek_found)
    );

    seat_rotator u_winner (
        .mask_i  (active_q),
        .start_i (3'd0),
        .idx_o   (win_idx),
        .found_o (win_found)
    );

    always_comb begin
        if (fold)               act = act_fold;
        else if (bet_or_raise)  act = act_bet_raise;
        else if (check_or_call) act = act_check_call;
        else                    act = act_none;

        owe         = cur_bet_q - contrib_q[ptr_q];
        target_wide = {1'b0, cur_bet_q} + (CHIP_W+1)'(BET_UNIT);
        target      = target_wide[CHIP_W] ? '1 : target_wide[CHIP_W-1:0];
        need        = (act == act_bet_raise) ? (target - contrib_q[ptr_q]) : owe;
        amt         = (need < stk[ptr_q]) ? need : stk[ptr_q];
        new_contrib = contrib_q[ptr_q] + amt;
    end

    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        acted_d      = acted_q;
        ptr_d        = ptr_q;
        cur_bet_d    = cur_bet_q;
        contrib_d    = contrib_q;
        make_bet_d   = 1'b0;
        player_en_d  = '0;
        bet_amt_d    = '0;
        round_done_d = 1'b0;
        hand_won_d   = 1'b0;
        winner_d     = '0;

        case (state_q)
            S_IDLE: begin
                if (start && !busy_q) begin
                    active_d  = active_in;
                    ptr_d     = first_seat;
                    acted_d   = '0;
                    cur_bet_d = '0;
                    for (int i = 0; i < 8; i++) contrib_d[i] = '0;
                    state_d   = S_SEEK;
                end
            end
            S_SEEK: begin
                if (seek_found) begin
                    ptr_d   = seek_idx;
                    state_d = S_WAIT_ACT;
                end else begin
                    round_done_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_WAIT_ACT: begin
                // The bet is resolved on this edge so make_bet is registered in APPLY
                if (advance && (act != act_none)) begin
                    state_d = S_APPLY;
                    if (act == act_fold) begin
                        active_d[ptr_q] = 1'b0;
                    end else begin
                        if (amt != '0) begin
                            make_bet_d         = 1'b1;
                            player_en_d[ptr_q] = 1'b1;
                            bet_amt_d          = amt;
                        end
                        contrib_d[ptr_q] = new_contrib;
                        if (new_contrib > cur_bet_q) begin
                            cur_bet_d = new_contrib;
                            acted_d   = '0;
                        end
                        acted_d[ptr_q] = 1'b1;
                    end
                end
            end
            S_APPLY: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if ((popcount8(active_q) == 4'd1) && win_found) begin
                    hand_won_d = 1'b1;
                    winner_d   = win_idx;
                    state_d    = S_IDLE;
                end else if (closed) begin
                    round_done_d = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    ptr_d   = ptr_q + 3'd1;
                    state_d = S_SEEK;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE) || round_done_d || hand_won_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            active_q     <= '0;
            acted_q      <= '0;
            ptr_q        <= '0;
            cur_bet_q    <= '0;
            for (int i = 0; i < 8; i++) contrib_q[i] <= '0;
            busy_q       <= 1'b0;
            make_bet_q   <= 1'b0;
            player_en_q  <= '0;
            bet_amt_q    <= '0;
            round_done_q <= 1'b0;
            hand_won_q   <= 1'b0;
            winner_q     <= '0;
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            acted_q      <= acted_d;
            ptr_q        <= ptr_d;
            cur_bet_q    <= cur_bet_d;
            contrib_q    <= contrib_d;
            busy_q       <= busy_d;
            make_bet_q   <= make_bet_d;
            player_en_q  <= player_en_d;
            bet_amt_q    <= bet_amt_d;
            round_done_q <= round_done_d;
            hand_won_q   <= hand_won_d;
            winner_q     <= winner_d;
        end
    end

    assign busy        = busy_q;
    assign player_turn = ptr_q;
    assign player_en   = player_en_q;
    assign make_bet    = make_bet_q;
    assign bet_amount  = bet_amt_q;
    assign pot_add     = bet_amt_q;
    assign active_out  = active_q;
    assign round_done  = round_done_q;
    assign hand_won    = hand_won_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_betting_round_ctrl.sv
// Directed bench for betting_round_ctrl: table of per-action steps plus hand-written corner sequences.
module tb_betting_round_ctrl;
    import betting_round_ctrl_pkg::*;

    localparam int CW = 10;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [7:0]      active_in = '0;
    logic [2:0]      first_seat = '0;
    logic            advance = 1'b0;
    logic            cc = 1'b0, br = 1'b0, fd = 1'b0;
    logic [8*CW-1:0] stacks = '0;
    logic            busy, make_bet, round_done, hand_won;
    logic [2:0]      player_turn, winner;
    logic [7:0]      player_en, active_out;
    logic [CW-1:0]   bet_amount, pot_add;

    betting_round_ctrl #(.BET_UNIT(10), .CHIP_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .active_in(active_in),
        .first_seat(first_seat), .advance(advance), .check_or_call(cc),
        .bet_or_raise(br), .fold(fd), .stacks(stacks), .busy(busy),
        .player_turn(player_turn), .player_en(player_en), .make_bet(make_bet),
        .bet_amount(bet_amount), .pot_add(pot_add), .active_out(active_out),
        .round_done(round_done), .hand_won(hand_won), .winner(winner)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    typedef struct {
        bit              st;
        logic [7:0]      act_in;
        logic [2:0]      first;
        logic [8*CW-1:0] stk;
        action_t         act;
        logic [2:0]      turn;
        logic [7:0]      en;
        logic [CW-1:0]   amt;
        logic [7:0]      act_out;
        int              fin;      // 0 continue, 1 round_done, 2 hand_won
        logic [2:0]      win;
    } vec_t;

    vec_t vt [16];

    task automatic drive_action(input action_t a);
        cc = (a == act_check_call);
        br = (a == act_bet_raise);
        fd = (a == act_fold);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_make_bet"}, make_bet, 0);
        chk({tag, "_player_en"}, player_en, 0);
        chk({tag, "_bet_amount"}, bet_amount, 0);
        chk({tag, "_pot_add"}, pot_add, 0);
        chk({tag, "_round_done"}, round_done, 0);
        chk({tag, "_hand_won"}, hand_won, 0);
        chk({tag, "_winner"}, winner, 0);
        chk({tag, "_turn"}, player_turn, 0);
        chk({tag, "_active_out"}, active_out, 0);
    endtask

    // Player side: deduct the bet from the enabled seat before the CHECK edge
    task automatic pay_bet();
        for (int i = 0; i < 8; i++)
            if (player_en[i]) stacks[i*CW +: CW] = stacks[i*CW +: CW] - bet_amount;
    endtask

    // Entered at a negedge: IDLE with busy=0 for start steps, WAIT_ACT otherwise.
    task automatic do_step(input int k, input vec_t v);
        string s;
        s = $sformatf("v%0d", k);
        if (v.st) begin
            stacks = v.stk; active_in = v.act_in; first_seat = v.first; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk({s, "_busy_seek"}, busy, 1);
            @(negedge clk);
        end
        chk({s, "_turn"}, player_turn, v.turn);
        advance = 1'b1;
        drive_action(v.act);
        @(negedge clk);
        advance = 1'b0;
        drive_action(act_none);
        chk({s, "_make_bet"}, make_bet, (v.amt != 0));
        chk({s, "_player_en"}, player_en, v.en);
        chk({s, "_bet_amount"}, bet_amount, v.amt);
        chk({s, "_pot_add"}, pot_add, v.amt);
        chk({s, "_active_out"}, active_out, v.act_out);
        if (make_bet) pay_bet();
        @(negedge clk);
        chk({s, "_no_early_done"}, round_done | hand_won, 0);
        @(negedge clk);
        chk({s, "_round_done"}, round_done, (v.fin == 1));
        chk({s, "_hand_won"}, hand_won, (v.fin == 2));
        if (v.fin == 2) chk({s, "_winner"}, winner, v.win);
        @(negedge clk);
        if (v.fin != 0) chk({s, "_busy_after"}, busy, 0);
        else            chk({s, "_busy_mid"}, busy, 1);
    endtask

    initial begin
        logic [8*CW-1:0] s100, sshort;
        s100   = {8{10'd100}};
        sshort = {{6{10'd100}}, 10'd4, 10'd100};

        // all check
        vt[0]  = '{1'b1, 8'h07, 3'd0, s100,   act_check_call, 3'd0, 8'h00, 10'd0,  8'h07, 0, 3'd0};
        vt[1]  = '{1'b0, 8'h07, 3'd0, s100,   act_check_call, 3'd1, 8'h00, 10'd0,  8'h07, 0, 3'd0};
        vt[2]  = '{1'b0, 8'h07, 3'd0, s100,   act_check_call, 3'd2, 8'h00, 10'd0,  8'h07, 1, 3'd0};
        // bet, call, call
        vt[3]  = '{1'b1, 8'h07, 3'd0, s100,   act_bet_raise,  3'd0, 8'h01, 10'd10, 8'h07, 0, 3'd0};
        vt[4]  = '{1'b0, 8'h07, 3'd0, s100,   act_check_call, 3'd1, 8'h02, 10'd10, 8'h07, 0, 3'd0};
        vt[5]  = '{1'b0, 8'h07, 3'd0, s100,   act_check_call, 3'd2, 8'h04, 10'd10, 8'h07, 1, 3'd0};
        // raise chain, seat 0 re-polled
        vt[6]  = '{1'b1, 8'h07, 3'd0, s100,   act_bet_raise,  3'd0, 8'h01, 10'd10, 8'h07, 0, 3'd0};
        vt[7]  = '{1'b0, 8'h07, 3'd0, s100,   act_bet_raise,  3'd1, 8'h02, 10'd20, 8'h07, 0, 3'd0};
        vt[8]  = '{1'b0, 8'h07, 3'd0, s100,   act_check_call, 3'd2, 8'h04, 10'd20, 8'h07, 0, 3'd0};
        vt[9]  = '{1'b0, 8'h07, 3'd0, s100,   act_check_call, 3'd0, 8'h01, 10'd10, 8'h07, 1, 3'd0};
        // fold to one player
        vt[10] = '{1'b1, 8'h05, 3'd2, s100,   act_fold,       3'd2, 8'h00, 10'd0,  8'h01, 2, 3'd0};
        // short stack calls all-in
        vt[11] = '{1'b1, 8'h07, 3'd0, sshort, act_bet_raise,  3'd0, 8'h01, 10'd10, 8'h07, 0, 3'd0};
        vt[12] = '{1'b0, 8'h07, 3'd0, sshort, act_check_call, 3'd1, 8'h02, 10'd4,  8'h07, 0, 3'd0};
        vt[13] = '{1'b0, 8'h07, 3'd0, sshort, act_check_call, 3'd2, 8'h04, 10'd10, 8'h07, 1, 3'd0};
        // seat search wraps past 7
        vt[14] = '{1'b1, 8'h81, 3'd5, s100,   act_bet_raise,  3'd7, 8'h80, 10'd10, 8'h81, 0, 3'd0};
        vt[15] = '{1'b0, 8'h81, 3'd5, s100,   act_check_call, 3'd0, 8'h01, 10'd10, 8'h81, 1, 3'd0};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 16; k++) do_step(k, vt[k]);

        // advance without an action, then start while busy: both ignored
        stacks = s100; active_in = 8'h07; first_seat = 3'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("ign_turn0", player_turn, 0);
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        chk("ign_adv_make_bet", make_bet, 0);
        chk("ign_adv_turn", player_turn, 0);
        active_in = 8'hFF; first_seat = 3'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_start_turn", player_turn, 0);
        chk("ign_start_active", active_out, 8'h07);
        chk("ign_start_busy", busy, 1);
        advance = 1'b1;
        drive_action(act_bet_raise);
        @(negedge clk);
        advance = 1'b0;
        drive_action(act_none);
        chk("ign_bet_make_bet", make_bet, 1);
        chk("ign_bet_amount", bet_amount, 10);
        chk("ign_bet_en", player_en, 8'h01);

        // reset during APPLY
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("apply_rst");
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);

        // back in IDLE: a fresh round starts normally
        stacks = s100; active_in = 8'h07; first_seat = 3'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("post_rst_turn", player_turn, 2);
        chk("post_rst_active", active_out, 8'h07);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
